// File: rtl/netbus_pkg.sv
// Shared NetBus definitions: flit geometry, header field positions and receive FSM states.
package netbus_pkg;

    localparam int unsigned SOF_BIT  = 13;
    localparam int unsigned EOF_BIT  = 12;
    localparam int unsigned DEST_LSB = 7;
    localparam int unsigned DEST_MSB = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } rx_state_e;

    // Nine bits per payload lane plus the 14-bit header.
    function automatic int unsigned flit_width(input int unsigned data_width);
        return data_width * 9 + 14;
    endfunction

endpackage

// File: rtl/netbus_slice_rx_sync_if.sv
// Flit-in / flit-out handshake bundle of the receive slice.
interface netbus_slice_rx_sync_if
    import netbus_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 4
);
    localparam int unsigned FW = flit_width(DATA_WIDTH);

    logic [FW-1:0] WDATA;
    logic          WVALID;
    logic          WREADY;
    logic [FW-1:0] RDATA;
    logic          RVALID;
    logic          RREADY;
    logic          RFRAME;

    modport master (
        output WDATA, WVALID, RREADY,
        input  WREADY, RDATA, RVALID, RFRAME
    );

    modport slave (
        input  WDATA, WVALID, RREADY,
        output WREADY, RDATA, RVALID, RFRAME
    );

endinterface

// File: rtl/netbus_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; head entry is read straight from the array.
module netbus_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q;
    logic [PW-1:0]    rptr_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign level_o = wptr_q - rptr_q;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + PW'(1);
            if (pop_ok)  rptr_q <= rptr_q + PW'(1);
        end
    end

    // Storage needs no reset; occupancy is defined by the pointers alone.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/netbus_slice_rx_sync.sv
// Frame-aware NetBus receive slice: route filter, pass/drop FSM, drop counter and output FIFO.
module netbus_slice_rx_sync
    import netbus_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 4,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [31:0] ROUTE_RESET = 32'h0000_0000,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                          CLK,
    input  logic                          RESETn,
    input  logic                          ROUTE_WE,
    input  logic [31:0]                   ROUTE_WDATA,
    input  logic                          DROP_EN,
    input  logic                          DROP_CLR,
    netbus_slice_rx_sync_if.slave         bus,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
    output logic [CNT_WIDTH-1:0]          DROP_CNT
);
    localparam int unsigned FW = flit_width(DATA_WIDTH);

    rx_state_e            state_q, state_d;
    logic [31:0]          route_q;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic       sof, eof, hit, keep;
    logic [4:0] dest;
    logic       wready_c, accept, push, discard;
    logic       full, empty;

    // Header decode and flit disposition; a SOF is always re-evaluated regardless of state.
    always_comb begin
        sof      = bus.WDATA[SOF_BIT];
        eof      = bus.WDATA[EOF_BIT];
        dest     = bus.WDATA[DEST_MSB:DEST_LSB];
        hit      = route_q[dest];
        wready_c = 1'b0;
        keep     = 1'b0;
        state_d  = state_q;

        if (sof) begin
            keep     = hit;
            wready_c = hit ? ~full : DROP_EN;
        end else begin
            unique case (state_q)
                PASS: begin
                    keep     = 1'b1;
                    wready_c = ~full;
                end
                default: begin
                    keep     = 1'b0;
                    wready_c = 1'b1;
                end
            endcase
        end

        if (!RESETn) wready_c = 1'b0;

        accept  = bus.WVALID & wready_c;
        push    = accept & keep;
        discard = accept & ~keep;

        // Stray flits never open a frame.
        if (accept) begin
            if (eof || (!sof && state_q == IDLE)) state_d = IDLE;
            else                                  state_d = keep ? PASS : DROP;
        end
    end

    // Saturating drop counter; clear wins over a same-cycle drop.
    always_comb begin
        cnt_d = cnt_q;
        if (DROP_CLR)                        cnt_d = '0;
        else if (discard && (cnt_q != '1))   cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state_q <= IDLE;
            route_q <= ROUTE_RESET;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (ROUTE_WE) route_q <= ROUTE_WDATA;
        end
    end

    netbus_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_ni  (RESETn),
        .push_i  (push),
        .wdata_i (bus.WDATA),
        .pop_i   (bus.RREADY),
        .rdata_o (bus.RDATA),
        .full_o  (full),
        .empty_o (empty),
        .level_o (FIFO_LEVEL)
    );

    assign bus.WREADY = wready_c;
    assign bus.RVALID = ~empty;
    assign bus.RFRAME = ~empty & bus.RDATA[EOF_BIT];
    assign DROP_CNT   = cnt_q;

endmodule

// File: doc/netbus_slice_rx_sync.md
Name: netbus_slice_rx_sync

Overview:
Single-clock, frame-aware receive slice for the NetBus flit stream. It filters frames by destination ID against a runtime route mask and buffers accepted flits in a parametrised synchronous FIFO. Unmatched frames are either back-pressured or consumed and dropped, selectable per mode, with a saturating drop counter. It sits between a bus segment and a local endpoint where both share one clock domain.

Parameters:
DATA_WIDTH, 4, payload lanes; flit width FW = DATA_WIDTH*9+14.
FIFO_DEPTH, 8, FIFO entries; power of two, minimum 2.
ROUTE_RESET, 32'h00000000, ROUTE_MASK register value after reset.
CNT_WIDTH, 16, DROP_CNT width.

Ports:
CLK  in  1  single clock; all logic rising-edge.
RESETn  in  1  synchronous, active-low reset.
ROUTE_WE  in  1  load ROUTE_WDATA into route mask register.
ROUTE_WDATA  in  32  new route mask; bit k set = accept dest ID k.
DROP_EN  in  1  1 = consume and discard unmatched frames; 0 = stall them.
DROP_CLR  in  1  clear DROP_CNT.
WDATA  in  FW  input flit; [13]=SOF, [12]=EOF, [11:7]=dest ID.
WVALID  in  1  input flit valid.
WREADY  out  1  input flit accepted when WVALID&WREADY.
RDATA  out  FW  head-of-FIFO flit.
RVALID  out  1  FIFO non-empty.
RREADY  in  1  consumer accepts RDATA.
RFRAME  out  1  RVALID & RDATA[12]; marks last flit of the frame on output.
FIFO_LEVEL  out  clog2(FIFO_DEPTH)+1  current entry count.
DROP_CNT  out  CNT_WIDTH  dropped-flit count, saturating.

Behaviour:
- Reset: synchronous while RESETn=0; state IDLE, FIFO empty, RVALID=0, RFRAME=0, WREADY=0, FIFO_LEVEL=0, DROP_CNT=0, route mask=ROUTE_RESET.
- Route match: hit = route_mask[WDATA[11:7]]. Evaluated only on SOF flits. Decision locked for the whole frame; ROUTE_WE mid-frame affects only the next SOF. ROUTE_WE takes effect the cycle after it is asserted.
- FSM states: IDLE, PASS, DROP.
- IDLE, SOF, hit: WREADY=~full. On accept, push the flit. Next state is PASS, or IDLE if EOF is also set.
- IDLE, SOF, miss, DROP_EN=1: WREADY=1. Flit is discarded and DROP_CNT increments. Next state is DROP, or IDLE if EOF.
- IDLE, SOF, miss, DROP_EN=0: WREADY=0. No state change; this is the stall mode.
- IDLE, no SOF (stray flit): WREADY=1, flit discarded, DROP_CNT increments, stay IDLE.
- PASS: WREADY=~full. Every accepted flit is pushed. EOF goes to IDLE. SOF inside PASS (missing EOF) is treated as a new header and evaluated exactly as in IDLE in the same cycle.
- DROP: WREADY=1. Every flit is discarded and counted. EOF goes to IDLE. SOF is re-evaluated as in IDLE.
- DROP_EN is sampled only at SOF evaluation.
- FIFO: write-first latency 1. A flit accepted in cycle N gives RVALID=1 in cycle N+1. RDATA is driven from the register array at the read pointer.
- WREADY depends only on full and state. There is no combinational path from RREADY to WREADY.
- At full with simultaneous pop: WREADY stays 0 that cycle. The freed slot is visible next cycle.
- Push and pop in the same cycle leave FIFO_LEVEL unchanged.
- Pointers are clog2(FIFO_DEPTH)+1 bits wide and wrap naturally. full = MSB differs and the rest is equal; empty = pointers equal.
- DROP_CNT saturates at all-ones. DROP_CLR has priority over an increment in the same cycle; the result is 0.
- Reset mid-frame: FIFO contents are discarded, FSM returns to IDLE, and the remaining flits of the interrupted frame are handled as stray flits.

Decomposition:
- Package netbus_pkg holds:
  - function flit_width(DATA_WIDTH);
  - field constants SOF_BIT=13, EOF_BIT=12, DEST_LSB=7, DEST_MSB=11;
  - FSM state enum {IDLE, PASS, DROP}.
- Sub-module netbus_sync_fifo: single-clock FIFO with parameters WIDTH and DEPTH, ports push/pop/full/empty/level. It is reused by other single-clock slices.
- The top level contains the FSM, the route register and the counter.

Test Plan:
- Route mask 32'h00000010, 3-flit frame to ID 4, RREADY=1 -> 3 flits out in order, RFRAME=1 on flit 3 only, DROP_CNT=0.
- Mask 0, DROP_EN=1, 4-flit frame to ID 9 -> WREADY=1 for 4 cycles, RVALID stays 0, DROP_CNT=4.
- Mask 0, DROP_EN=0, frame to ID 9 -> WREADY=0 indefinitely. Then ROUTE_WE with 32'h00000200 -> frame accepted from the following cycle.
- FIFO_DEPTH=8, RREADY=0, 10-flit matching frame -> 8 accepted, WREADY=0, FIFO_LEVEL=8. Pulse RREADY for one cycle -> level goes 7 and the next flit is accepted the cycle after.
- ROUTE_WE clears mask during the 2nd flit of a matching 5-flit frame -> all 5 flits delivered; next frame to the same ID is dropped when DROP_EN=1.
- DROP_CNT at 16'hFFFF plus a dropped flit -> stays FFFF. DROP_CLR together with a dropped flit -> 0. RESETn low mid-frame -> RVALID=0, FIFO_LEVEL=0, and the remaining flits are counted as strays.
